// File: rtl/tawas_thread_sched.sv
// Round-robin hardware thread scheduler: picks one ready thread per cycle,
// issues its PC as a fetch, and tracks busy/run state and the PC table.
module tawas_thread_sched #(
  parameter int NTHREADS  = 32,
  parameter int TID_W     = 5,
  parameter int PC_W      = 24,
  parameter bit RESET_RUN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NTHREADS-1:0] thread_mask,
  input  logic                fetch_stall,
  output logic                ics,
  output logic [PC_W-1:0]     iaddr,
  output logic [TID_W-1:0]    fetch_tid,
  output logic                fetch_half,
  input  logic                pc_update_en,
  input  logic [TID_W-1:0]    pc_update_sel,
  input  logic [PC_W:0]       pc_update_addr,
  input  logic                pc_update_halt,
  input  logic                retire_en,
  input  logic [TID_W-1:0]    retire_tid,
  input  logic                start_en,
  input  logic [TID_W-1:0]    start_tid,
  input  logic [PC_W-1:0]     start_pc,
  output logic                start_ok,
  output logic [NTHREADS-1:0] thread_running,
  output logic [31:0]         issue_cnt
);

  // Handshake: ics is a one-cycle strobe with no back-pressure from the
  // memory side; fetch_stall is the only throttle and suppresses the pick.
  logic [PC_W:0]         pc_q [NTHREADS];
  logic [NTHREADS-1:0]   run_q;
  logic [NTHREADS-1:0]   busy_q;
  logic [NTHREADS-1:0]   ready;
  logic [TID_W-1:0]      rr_q;
  logic [TID_W-1:0]      pick_tid;
  logic [TID_W-1:0]      idx_t;
  logic                  pick_valid;
  logic                  issue;
  logic                  start_acc;
  logic                  update_ok;
  logic                  retire_ok;
  int                    idx;

  function automatic logic tid_ok(input logic [TID_W-1:0] t);
    return int'(t) < NTHREADS;
  endfunction

  assign ready = run_q & ~busy_q & thread_mask;

  // Scan from the farthest offset down so the nearest ready thread after
  // rr_q is the one left standing.
  always_comb begin
    pick_valid = 1'b0;
    pick_tid   = '0;
    idx        = 0;
    idx_t      = '0;
    for (int k = NTHREADS; k >= 1; k--) begin
      idx   = (int'(rr_q) + k) % NTHREADS;
      idx_t = TID_W'(idx);
      if (ready[idx_t]) begin
        pick_valid = 1'b1;
        pick_tid   = idx_t;
      end
    end
  end

  assign issue     = pick_valid & ~fetch_stall;
  assign update_ok = pc_update_en & tid_ok(pc_update_sel);
  assign retire_ok = retire_en & tid_ok(retire_tid);
  // Busy is sampled before the edge, so a same-cycle retire does not help a start.
  assign start_acc = start_en & tid_ok(start_tid) & ~run_q[start_tid] & ~busy_q[start_tid];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTHREADS; i++) pc_q[i] <= (PC_W+1)'(i);
    end else begin
      if (update_ok) pc_q[pc_update_sel] <= pc_update_addr;
      if (start_acc) pc_q[start_tid] <= {1'b0, start_pc};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q     <= {NTHREADS{RESET_RUN}};
      busy_q    <= '0;
      rr_q      <= TID_W'(NTHREADS - 1);
      ics       <= 1'b0;
      iaddr     <= '0;
      fetch_tid <= '0;
      fetch_half <= 1'b0;
      start_ok  <= 1'b0;
      issue_cnt <= '0;
    end else begin
      if (update_ok && pc_update_halt) run_q[pc_update_sel] <= 1'b0;
      if (start_acc) run_q[start_tid] <= 1'b1;
      if (retire_ok) busy_q[retire_tid] <= 1'b0;
      if (issue) begin
        busy_q[pick_tid] <= 1'b1;
        rr_q             <= pick_tid;
        iaddr            <= pc_q[pick_tid][PC_W-1:0];
        fetch_half       <= pc_q[pick_tid][PC_W];
        fetch_tid        <= pick_tid;
        issue_cnt        <= issue_cnt + 32'd1;
      end
      ics      <= issue;
      start_ok <= start_acc;
    end
  end

  assign thread_running = run_q;

endmodule

// File: tb/tb_tawas_thread_sched.sv
// Bench for tawas_thread_sched: cycle model feeding an expected-output queue,
// plus scenario tasks with directed checks.
module tb_tawas_thread_sched;

  localparam int N     = 32;
  localparam int EXP_W = 96;

  typedef struct packed {
    logic        ics;
    logic [4:0]  tid;
    logic [23:0] addr;
    logic        half;
    logic        sok;
    logic [31:0] run;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] thread_mask = '0;
  logic        fetch_stall = 1'b0;
  logic        ics;
  logic [23:0] iaddr;
  logic [4:0]  fetch_tid;
  logic        fetch_half;
  logic        pc_update_en = 1'b0;
  logic [4:0]  pc_update_sel = '0;
  logic [24:0] pc_update_addr = '0;
  logic        pc_update_halt = 1'b0;
  logic        retire_en = 1'b0;
  logic [4:0]  retire_tid = '0;
  logic        start_en = 1'b0;
  logic [4:0]  start_tid = '0;
  logic [23:0] start_pc = '0;
  logic        start_ok;
  logic [31:0] thread_running;
  logic [31:0] issue_cnt;

  tawas_thread_sched dut (
    .clk(clk), .rst(rst), .thread_mask(thread_mask), .fetch_stall(fetch_stall),
    .ics(ics), .iaddr(iaddr), .fetch_tid(fetch_tid), .fetch_half(fetch_half),
    .pc_update_en(pc_update_en), .pc_update_sel(pc_update_sel),
    .pc_update_addr(pc_update_addr), .pc_update_halt(pc_update_halt),
    .retire_en(retire_en), .retire_tid(retire_tid),
    .start_en(start_en), .start_tid(start_tid), .start_pc(start_pc),
    .start_ok(start_ok), .thread_running(thread_running), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [24:0] m_pc [N];
  logic [31:0] m_run, m_busy, m_cnt;
  int          m_rr;
  logic [4:0]  m_tid;
  logic [23:0] m_addr;
  logic        m_half;
  int          ret_delay [N];
  int          due [N];
  int          cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pc[i] = 25'(i);
      due[i]  = -1;
    end
    m_run = '1; m_busy = '0; m_cnt = '0; m_rr = N - 1;
    m_tid = '0; m_addr = '0; m_half = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [31:0] rdy;
    int p, i;
    logic go, acc;
    exp_t e;
    rdy = m_run & ~m_busy & thread_mask;
    p = -1;
    i = m_rr;
    for (int n = 0; n < N; n++) begin
      i = (i == N - 1) ? 0 : i + 1;
      if (p < 0 && rdy[i]) p = i;
    end
    go = (p >= 0) && !fetch_stall;
    acc = start_en && !m_run[start_tid] && !m_busy[start_tid];
    if (go) begin
      m_tid  = 5'(p);
      m_addr = m_pc[p][23:0];
      m_half = m_pc[p][24];
      m_cnt  = m_cnt + 1;
    end
    if (retire_en) m_busy[retire_tid] = 1'b0;
    if (go) begin
      m_busy[p] = 1'b1;
      m_rr = p;
    end
    if (pc_update_en) begin
      m_pc[pc_update_sel] = pc_update_addr;
      if (pc_update_halt) m_run[pc_update_sel] = 1'b0;
    end
    if (acc) begin
      m_pc[start_tid] = {1'b0, start_pc};
      m_run[start_tid] = 1'b1;
    end
    e = '{ics: go, tid: m_tid, addr: m_addr, half: m_half, sok: acc, run: m_run, cnt: m_cnt};
    exp_q.push_back(EXP_W'(e));
  endtask

  // One clock: model at the active edge, compare on the falling edge, then
  // schedule the next retire from the per-thread delay table.
  task automatic tick();
    exp_t e, got;
    logic have_e;
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    got = {ics, fetch_tid, iaddr, fetch_half, start_ok, thread_running, issue_cnt};
    have_e = 1'b0;
    n_run++;
    if (exp_q.size() != 0) begin
      e = exp_t'(exp_q.pop_front());
      have_e = 1'b1;
      if (got !== e) begin
        n_fail++;
        $display("FAIL scoreboard cyc=%0d: got ics=%0b tid=%0d addr=%h half=%0b ok=%0b run=%h cnt=%0d, expected ics=%0b tid=%0d addr=%h half=%0b ok=%0b run=%h cnt=%0d",
                 cyc, got.ics, got.tid, got.addr, got.half, got.sok, got.run, got.cnt,
                 e.ics, e.tid, e.addr, e.half, e.sok, e.run, e.cnt);
      end
    end else if (ics !== 1'b0 || issue_cnt !== 32'd0 || start_ok !== 1'b0 || thread_running !== '1) begin
      n_fail++;
      $display("FAIL reset_idle cyc=%0d: got ics=%0b cnt=%0d ok=%0b run=%h, expected 0 0 0 ffffffff",
               cyc, ics, issue_cnt, start_ok, thread_running);
    end
    if (have_e && e.ics && ret_delay[e.tid] >= 0) due[e.tid] = cyc + ret_delay[e.tid];
    retire_en = 1'b0;
    retire_tid = '0;
    for (int t = 0; t < N; t++) begin
      if (!retire_en && due[t] >= 0 && due[t] <= cyc) begin
        retire_en = 1'b1;
        retire_tid = 5'(t);
        due[t] = -1;
      end
    end
    cyc++;
  endtask

  task automatic set_delays(input int d);
    for (int i = 0; i < N; i++) ret_delay[i] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fetch_stall = 1'b0; pc_update_en = 1'b0; pc_update_halt = 1'b0;
    start_en = 1'b0; retire_en = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    thread_mask = '1;
    set_delays(3);
    do_reset();
    n_run++;
    if (ics !== 1'b0 || iaddr !== 24'd0 || fetch_tid !== 5'd0 || fetch_half !== 1'b0 ||
        start_ok !== 1'b0 || issue_cnt !== 32'd0 || thread_running !== 32'hffff_ffff) begin
      n_fail++;
      $display("FAIL reset_values: got ics=%0b addr=%h tid=%0d half=%0b ok=%0b cnt=%0d run=%h, expected all zero, run=ffffffff",
               ics, iaddr, fetch_tid, fetch_half, start_ok, issue_cnt, thread_running);
    end
  endtask

  task automatic test_round_robin();
    int idle;
    thread_mask = '1;
    set_delays(3);
    do_reset();
    idle = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!ics) idle++;
      if (i <= 8) begin
        n_run++;
        if (ics !== 1'b1 || fetch_tid !== 5'(i - 1) || iaddr !== 24'(i - 1)) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got ics=%0b tid=%0d addr=%h, expected 1 %0d %h", i, ics, fetch_tid, iaddr, i - 1, i - 1);
        end
      end
    end
    n_run++;
    if (idle != 0 || issue_cnt !== 32'd40) begin
      n_fail++;
      $display("FAIL rr_steady: got idle=%0d cnt=%0d, expected 0 40", idle, issue_cnt);
    end
  endtask

  task automatic test_mask();
    int exp_seq [8] = '{0, 2, -1, 2, -1, 2, -1, 2};
    int obs;
    thread_mask = 32'h5;
    set_delays(3);
    ret_delay[0] = -1;
    ret_delay[2] = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      obs = ics ? int'(fetch_tid) : -1;
      n_run++;
      if (obs != exp_seq[i]) begin
        n_fail++;
        $display("FAIL mask_seq[%0d]: got %0d, expected %0d", i, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stall();
    thread_mask = '1;
    set_delays(3);
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    fetch_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_run++;
      if (ics !== 1'b0 || issue_cnt !== 32'd5 || iaddr !== 24'd4 || fetch_tid !== 5'd4) begin
        n_fail++;
        $display("FAIL stall[%0d]: got ics=%0b cnt=%0d addr=%h tid=%0d, expected 0 5 000004 4", i, ics, issue_cnt, iaddr, fetch_tid);
      end
    end
    fetch_stall = 1'b0;
    tick();
    n_run++;
    if (ics !== 1'b1 || fetch_tid !== 5'd5 || issue_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL stall_resume: got ics=%0b tid=%0d cnt=%0d, expected 1 5 6", ics, fetch_tid, issue_cnt);
    end
  endtask

  task automatic test_pc_update_halt();
    int seen3, seen7, bad7;
    thread_mask = '1;
    set_delays(3);
    do_reset();
    pc_update_en = 1'b1; pc_update_sel = 5'd3; pc_update_addr = 25'h1_000100; pc_update_halt = 1'b1;
    tick();
    pc_update_sel = 5'd7; pc_update_addr = 25'h1_000123; pc_update_halt = 1'b0;
    tick();
    pc_update_en = 1'b0;
    due[3] = cyc;
    seen3 = 0; seen7 = 0; bad7 = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (ics && fetch_tid == 5'd3) seen3++;
      if (ics && fetch_tid == 5'd7) begin
        seen7++;
        if (iaddr !== 24'h000123 || fetch_half !== 1'b1) bad7++;
      end
    end
    n_run++;
    if (seen3 != 0 || thread_running[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_thread3: got fetches=%0d running=%0b, expected 0 0", seen3, thread_running[3]);
    end
    n_run++;
    if (seen7 == 0 || bad7 != 0) begin
      n_fail++;
      $display("FAIL update_thread7: got fetches=%0d wrong_pc=%0d, expected >0 0", seen7, bad7);
    end
  endtask

  task automatic test_start();
    thread_mask = '0;
    set_delays(-1);
    do_reset();
    pc_update_en = 1'b1; pc_update_sel = 5'd3; pc_update_addr = 25'h1_000100; pc_update_halt = 1'b1;
    tick();
    pc_update_en = 1'b0; pc_update_halt = 1'b0;
    thread_mask = 32'h8;
    start_en = 1'b1; start_tid = 5'd3; start_pc = 24'h000200;
    tick();
    start_en = 1'b0;
    n_run++;
    if (start_ok !== 1'b1 || thread_running[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_idle: got ok=%0b running=%0b, expected 1 1", start_ok, thread_running[3]);
    end
    tick();
    n_run++;
    if (ics !== 1'b1 || fetch_tid !== 5'd3 || iaddr !== 24'h000200 || fetch_half !== 1'b0) begin
      n_fail++;
      $display("FAIL start_fetch: got ics=%0b tid=%0d addr=%h half=%0b, expected 1 3 000200 0", ics, fetch_tid, iaddr, fetch_half);
    end
    start_en = 1'b1; start_pc = 24'h000abc;
    tick();
    n_run++;
    if (start_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL start_running: got ok=%0b, expected 0", start_ok);
    end
    start_en = 1'b0;
    pc_update_en = 1'b1; pc_update_sel = 5'd3; pc_update_addr = 25'h0_000300; pc_update_halt = 1'b1;
    tick();
    pc_update_en = 1'b0; pc_update_halt = 1'b0;
    start_en = 1'b1;
    tick();
    n_run++;
    if (start_ok !== 1'b0 || thread_running[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy: got ok=%0b running=%0b, expected 0 0", start_ok, thread_running[3]);
    end
    retire_en = 1'b1; retire_tid = 5'd3;
    tick();
    n_run++;
    if (start_ok !== 1'b0 || thread_running[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_retire: got ok=%0b running=%0b, expected 0 0", start_ok, thread_running[3]);
    end
    start_pc = 24'h000240;
    tick();
    start_en = 1'b0;
    n_run++;
    if (start_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL start_after_retire: got ok=%0b, expected 1", start_ok);
    end
    tick();
    n_run++;
    if (ics !== 1'b1 || fetch_tid !== 5'd3 || iaddr !== 24'h000240) begin
      n_fail++;
      $display("FAIL restart_fetch: got ics=%0b tid=%0d addr=%h, expected 1 3 000240", ics, fetch_tid, iaddr);
    end
  endtask

  task automatic test_simultaneous_and_reset();
    thread_mask = '0;
    set_delays(3);
    do_reset();
    pc_update_en = 1'b1; pc_update_sel = 5'd5; pc_update_addr = 25'h0_000000; pc_update_halt = 1'b1;
    tick();
    start_en = 1'b1; start_tid = 5'd5; start_pc = 24'h000555;
    pc_update_addr = 25'h1_000777;
    tick();
    start_en = 1'b0; pc_update_en = 1'b0; pc_update_halt = 1'b0;
    n_run++;
    if (start_ok !== 1'b1 || thread_running[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_vs_update: got ok=%0b running=%0b, expected 1 1", start_ok, thread_running[5]);
    end
    thread_mask = 32'h20;
    tick();
    n_run++;
    if (ics !== 1'b1 || fetch_tid !== 5'd5 || iaddr !== 24'h000555 || fetch_half !== 1'b0) begin
      n_fail++;
      $display("FAIL start_wins_pc: got ics=%0b tid=%0d addr=%h half=%0b, expected 1 5 000555 0", ics, fetch_tid, iaddr, fetch_half);
    end
    thread_mask = '1;
    set_delays(-1);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0;
    model_reset();
    #1;
    n_run++;
    if (ics !== 1'b0 || issue_cnt !== 32'd0 || thread_running !== 32'hffff_ffff || iaddr !== 24'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got ics=%0b cnt=%0d run=%h addr=%h, expected 0 0 ffffffff 000000", ics, issue_cnt, thread_running, iaddr);
    end
    tick();
    rst = 1'b1;
    tick();
    n_run++;
    if (ics !== 1'b1 || fetch_tid !== 5'd0 || iaddr !== 24'd0 || issue_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL after_reset_pick: got ics=%0b tid=%0d addr=%h cnt=%0d, expected 1 0 000000 1", ics, fetch_tid, iaddr, issue_cnt);
    end
  endtask

  initial begin
    set_delays(3);
    model_reset();
    test_reset();
    test_round_robin();
    test_mask();
    test_stall();
    test_pc_update_halt();
    test_start();
    test_simultaneous_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
